// File: rtl/ssram_pkg.sv
// Shared constants and FSM state encoding for the quad-SPI serial SRAM controller.
package ssram_pkg;

  localparam logic [7:0] CMD_EQIO   = 8'h38;
  localparam logic [7:0] CMD_RSTQIO = 8'hFF;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_FREAD  = 8'h0B;

  localparam int ADDR_BITS = 24;

  typedef enum logic [3:0] {
    S_INIT_RSTQIO,
    S_INIT_GAP,
    S_INIT_EQIO,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_DESEL
  } state_t;

endpackage

// File: rtl/ssram_sclk_tick.sv
// SCLK divider: alternating rise/fall tick enables every CLK_DIV clocks and the
// registered SCLK, held low whenever chip select is inactive.
module ssram_sclk_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_active,
  output logic tick_rise,
  output logic tick_fall,
  output logic sclk
);

  logic [3:0] div_cnt;
  logic       ph;
  logic       tick;

  assign tick      = (div_cnt == 4'd0);
  assign tick_rise = tick & ~ph;
  assign tick_fall = tick & ph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 4'(CLK_DIV - 1);
      ph      <= 1'b0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= 4'(CLK_DIV - 1);
      ph      <= ~ph;
      // phase runs free so the deselect gap is measured in whole SCLK periods
      sclk    <= cs_active & ~ph;
    end else begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/ssram_qspi_burst.sv
// Quad-SPI serial SRAM burst controller with divided SCLK.
// Define SSRAM_RSTQIO_EN to send RSTQIO ahead of EQIO at initialisation.
//
// state         | meaning
// S_INIT_RSTQIO | quad 0xFF to drop a device left in QPI mode
// S_INIT_GAP    | raise CS for one SCLK before EQIO
// S_INIT_EQIO   | SPI-mode 0x38 on SIO0, SIO3 held high
// S_IDLE        | req_ready high, waiting for a request
// S_CMD         | two command nibbles
// S_ADDR        | six address nibbles, MSB first
// S_WDATA       | write bytes, high nibble first
// S_DUMMY       | bus released for DUMMY_CYC SCLKs
// S_RDATA       | sample read nibbles on SCLK rise
// S_DESEL       | raise CS, then hold it high one SCLK
module ssram_qspi_burst
  import ssram_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int LEN_W     = 8,
  parameter int DUMMY_CYC = 3,
  parameter int CLK_DIV   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic              sram_sclk,
  output logic              sram_cs_n,
  output logic [3:0]        sram_sio_o,
  output logic [3:0]        sram_sio_oe,
  input  logic [3:0]        sram_sio_i
);

`ifdef SSRAM_RSTQIO_EN
  localparam state_t S_BOOT = S_INIT_RSTQIO;
`else
  localparam state_t S_BOOT = S_INIT_EQIO;
`endif

  state_t               state;
  logic [ADDR_BITS+7:0] sh;
  logic [3:0]           cnt;
  logic [LEN_W-1:0]     byte_cnt;
  logic                 is_write;
  logic                 half;
  logic [3:0]           nib_hold;
  logic                 tick_rise;
  logic                 tick_fall;

  ssram_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .cs_active (~sram_cs_n),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .sclk      (sram_sclk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      sh          <= '0;
      cnt         <= '0;
      byte_cnt    <= '0;
      is_write    <= 1'b0;
      half        <= 1'b0;
      nib_hold    <= '0;
      sram_cs_n   <= 1'b1;
      sram_sio_o  <= '0;
      sram_sio_oe <= '0;
      req_ready   <= 1'b0;
      wr_ready    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      init_done   <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
`ifdef SSRAM_RSTQIO_EN
        S_INIT_RSTQIO: if (tick_fall) begin
          sram_sio_oe <= 4'hF;
          if (sram_cs_n) begin
            sram_cs_n  <= 1'b0;
            sram_sio_o <= CMD_RSTQIO[7:4];
          end else begin
            sram_sio_o <= CMD_RSTQIO[3:0];
            state      <= S_INIT_GAP;
          end
        end
        S_INIT_GAP: if (tick_fall) begin
          sram_cs_n   <= 1'b1;
          sram_sio_o  <= '0;
          sram_sio_oe <= '0;
          state       <= S_INIT_EQIO;
        end
`endif
        S_INIT_EQIO: if (tick_fall) begin
          sram_sio_oe <= 4'b1001;
          if (sram_cs_n) begin
            sram_cs_n  <= 1'b0;
            sram_sio_o <= {1'b1, 2'b00, CMD_EQIO[7]};
            cnt        <= 4'd6;
          end else begin
            sram_sio_o <= {1'b1, 2'b00, CMD_EQIO[cnt[2:0]]};
            if (cnt == 4'd0) state <= S_DESEL;
            else             cnt   <= cnt - 4'd1;
          end
        end
        S_IDLE: if (req_valid && req_ready) begin
          req_ready <= 1'b0;
          is_write  <= req_write;
          byte_cnt  <= req_len;
          sh        <= {(req_write ? CMD_WRITE : CMD_FREAD),
                        {(ADDR_BITS-ADDR_W){1'b0}}, req_addr};
          state     <= S_CMD;
        end
        S_CMD: if (tick_fall) begin
          sram_sio_oe <= 4'hF;
          sram_sio_o  <= sh[ADDR_BITS+7 -: 4];
          sh          <= {sh[ADDR_BITS+3:0], 4'h0};
          if (sram_cs_n) begin
            sram_cs_n <= 1'b0;
          end else begin
            state <= S_ADDR;
            cnt   <= 4'd5;
          end
        end
        S_ADDR: if (tick_fall) begin
          sram_sio_o <= sh[ADDR_BITS+7 -: 4];
          sh         <= {sh[ADDR_BITS+3:0], 4'h0};
          if (cnt == 4'd0) begin
            state <= is_write ? S_WDATA : S_DUMMY;
            half  <= 1'b0;
            // one extra tick: the last DUMMY tick launches the first read cycle
            cnt   <= 4'(DUMMY_CYC);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WDATA: if (tick_fall) begin
          if (!half) begin
            sram_sio_o <= wr_data[7:4];
            nib_hold   <= wr_data[3:0];
            wr_ready   <= 1'b1;
            half       <= 1'b1;
          end else begin
            sram_sio_o <= nib_hold;
            half       <= 1'b0;
            if (byte_cnt == '0) state    <= S_DESEL;
            else                byte_cnt <= byte_cnt - LEN_W'(1);
          end
        end
        S_DUMMY: if (tick_fall) begin
          sram_sio_oe <= '0;
          sram_sio_o  <= '0;
          if (cnt == 4'd0) state <= S_RDATA;
          else             cnt   <= cnt - 4'd1;
        end
        S_RDATA: if (tick_rise) begin
          if (!half) begin
            nib_hold <= sram_sio_i;
            half     <= 1'b1;
          end else begin
            rd_data  <= {nib_hold, sram_sio_i};
            rd_valid <= 1'b1;
            half     <= 1'b0;
            if (byte_cnt == '0) state    <= S_DESEL;
            else                byte_cnt <= byte_cnt - LEN_W'(1);
          end
        end
        S_DESEL: if (tick_fall) begin
          if (!sram_cs_n) begin
            sram_cs_n   <= 1'b1;
            sram_sio_o  <= '0;
            sram_sio_oe <= '0;
            init_done   <= 1'b1;
          end else begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
